spi_image_rx: RTL and testbench

//  SPI-slave front end of the OCR path. Samples the external SPI pins (SCLK, COPI, spi_cs_n) in the clk domain.

---
 rtl/spi_image_rx_pkg.sv | 16 +
 rtl/spi_image_rx_if.sv | 49 ++++
 rtl/spi_image_rx_sync_edge_detect.sv | 31 +++
 rtl/spi_image_rx.sv | 152 +++++++++++++++
 tb/tb_spi_image_rx.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_image_rx_pkg.sv
// Shared image geometry and receiver state encoding for the OCR SPI front end.
// A 32x32 binary image packs 8 pixels per byte, so one frame is 128 bytes.
package spi_image_rx_pkg;

    localparam int IMG_W      = 32;
    localparam int IMG_H      = 32;
    localparam int IMG_BYTES  = (IMG_W * IMG_H) / 8;
    localparam int IMG_ADDR_W = $clog2(IMG_BYTES);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_RECV,
        RX_DONE
    } rx_state_t;

endpackage

// File: rtl/spi_image_rx_if.sv
// Bundles the SPI pins, controller handshake and image-buffer write port of spi_image_rx.
// The receiver sits on the slave modport; the controller or bench drives the master side.
interface spi_image_rx_if
    import spi_image_rx_pkg::*;
#(
    parameter int ADDR_W = IMG_ADDR_W
) ();

    logic              SCLK;
    logic              COPI;
    logic              spi_cs_n;
    logic              rx_enable;
    logic              frame_clear;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_wdata;
    logic              image_done;
    logic              rx_busy;
    logic              overflow_err;

    modport slave (
        input  SCLK,
        input  COPI,
        input  spi_cs_n,
        input  rx_enable,
        input  frame_clear,
        output buf_we,
        output buf_addr,
        output buf_wdata,
        output image_done,
        output rx_busy,
        output overflow_err
    );

    modport master (
        output SCLK,
        output COPI,
        output spi_cs_n,
        output rx_enable,
        output frame_clear,
        input  buf_we,
        input  buf_addr,
        input  buf_wdata,
        input  image_done,
        input  rx_busy,
        input  overflow_err
    );

endinterface

// File: rtl/spi_image_rx_sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous pin, with edge pulses on the synced value.
// STAGES must be at least 2; rise/fall are combinational from the last stage and its delayed copy.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = chain[STAGES-1] & ~prev;
    assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_image_rx.sv
// SPI mode-0 slave that assembles MSB-first bytes and writes one binary image into the buffer.
// All outputs are registered; a byte write appears one clk after the synced SCLK edge of its 8th bit.
module spi_image_rx #(
    parameter int IMG_BYTES   = spi_image_rx_pkg::IMG_BYTES,
    parameter int ADDR_W      = spi_image_rx_pkg::IMG_ADDR_W,
    parameter int SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           rst,
    spi_image_rx_if.slave bus
);

    import spi_image_rx_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);

    logic sclk_rise;
    logic cs_q;
    logic cs_rise;
    logic copi_q;
    logic sclk_q_unused;
    logic sclk_fall_unused;
    logic cs_fall_unused;
    logic copi_rise_unused;
    logic copi_fall_unused;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.SCLK),
        .q    (sclk_q_unused),
        .rise (sclk_rise),
        .fall (sclk_fall_unused)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.spi_cs_n),
        .q    (cs_q),
        .rise (cs_rise),
        .fall (cs_fall_unused)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_copi (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.COPI),
        .q    (copi_q),
        .rise (copi_rise_unused),
        .fall (copi_fall_unused)
    );

    rx_state_t         state;
    logic [7:0]        sr;
    logic [2:0]        bit_cnt;
    logic [ADDR_W-1:0] ptr;

    logic       bit_take;
    logic       byte_complete;
    logic [7:0] sr_next;

    // A bit is taken only while the synced select is low; cs_rise implies cs_q=1, so the two never coincide.
    assign bit_take      = sclk_rise & ~cs_q;
    assign sr_next       = {sr[6:0], copi_q};
    assign byte_complete = bit_take && (bit_cnt == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= RX_IDLE;
            sr               <= '0;
            bit_cnt          <= '0;
            ptr              <= '0;
            bus.buf_we       <= 1'b0;
            bus.buf_addr     <= '0;
            bus.buf_wdata    <= '0;
            bus.image_done   <= 1'b0;
            bus.rx_busy      <= 1'b0;
            bus.overflow_err <= 1'b0;
        end else begin
            bus.buf_we     <= 1'b0;
            bus.image_done <= 1'b0;
            if (bus.frame_clear) begin
                state            <= RX_IDLE;
                bit_cnt          <= '0;
                ptr              <= '0;
                bus.rx_busy      <= 1'b0;
                bus.overflow_err <= 1'b0;
            end else begin
                case (state)
                    RX_IDLE: begin
                        bit_cnt <= '0;
                        if (bus.rx_enable && !cs_q) begin
                            state       <= RX_RECV;
                            bus.rx_busy <= 1'b1;
                        end
                    end
                    RX_RECV: begin
                        if (!bus.rx_enable) begin
                            state       <= RX_IDLE;
                            bit_cnt     <= '0;
                            bus.rx_busy <= 1'b0;
                        end else if (bit_take) begin
                            sr <= sr_next;
                            if (byte_complete) begin
                                bit_cnt       <= '0;
                                bus.buf_we    <= 1'b1;
                                bus.buf_wdata <= sr_next;
                                bus.buf_addr  <= ptr;
                                // The pointer restarts at the frame end instead of wrapping through.
                                if (ptr == LAST_ADDR) begin
                                    ptr            <= '0;
                                    bus.image_done <= 1'b1;
                                    bus.rx_busy    <= 1'b0;
                                    state          <= RX_DONE;
                                end else begin
                                    ptr <= ptr + ADDR_W'(1);
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else if (cs_rise) begin
                            bit_cnt <= '0;
                        end
                    end
                    RX_DONE: begin
                        if (!bus.rx_enable) begin
                            state   <= RX_IDLE;
                            bit_cnt <= '0;
                        end else if (bit_take) begin
                            sr <= sr_next;
                            if (byte_complete) begin
                                bit_cnt          <= '0;
                                bus.overflow_err <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else if (cs_rise) begin
                            bit_cnt <= '0;
                        end
                    end
                    default: begin
                        state       <= RX_IDLE;
                        bit_cnt     <= '0;
                        bus.rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_image_rx.sv
// Scoreboard bench for spi_image_rx: stimulus pushes expected buffer writes, a monitor pops and compares.
// SCLK runs at clk/8 with COPI changing on the falling SCLK edge.
module tb_spi_image_rx;

    import spi_image_rx_pkg::*;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        logic       done;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   done_count = 0;

    spi_image_rx_if #(.ADDR_W(7)) bus ();

    spi_image_rx #(
        .IMG_BYTES   (128),
        .ADDR_W      (7),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.COPI = b[7-i];
            wait_clk(4);
            bus.SCLK = 1'b1;
            wait_clk(4);
            bus.SCLK = 1'b0;
        end
    endtask

    // Sends one byte; when a write is expected its address/data/done are queued first.
    task automatic apply_stimulus(input logic [7:0] b, input bit expect_write, input int addr);
        exp_t e;
        if (expect_write) begin
            e.addr = 7'(addr);
            e.data = b;
            e.done = (addr == 127);
            exp_q.push_back(e);
        end
        send_bits(b, 8);
    endtask

    task automatic pulse_clear();
        bus.frame_clear = 1'b1;
        wait_clk(1);
        bus.frame_clear = 1'b0;
        wait_clk(1);
    endtask

    // Monitor: every write must match the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.image_done) done_count++;
                if (bus.buf_we) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_write_addr", 32'(bus.buf_addr), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("write_addr", 32'(bus.buf_addr), 32'(e.addr));
                        check_output("write_data", 32'(bus.buf_wdata), 32'(e.data));
                        check_output("write_done", 32'(bus.image_done), 32'(e.done));
                    end
                end else if (bus.image_done) begin
                    check_output("done_without_write", 32'(bus.image_done), 32'd0);
                end
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.SCLK        = 1'b0;
        bus.COPI        = 1'b0;
        bus.spi_cs_n    = 1'b1;
        bus.rx_enable   = 1'b0;
        bus.frame_clear = 1'b0;
        wait_clk(3);

        check_output("reset_buf_we", 32'(bus.buf_we), 32'd0);
        check_output("reset_buf_addr", 32'(bus.buf_addr), 32'd0);
        check_output("reset_buf_wdata", 32'(bus.buf_wdata), 32'd0);
        check_output("reset_image_done", 32'(bus.image_done), 32'd0);
        check_output("reset_rx_busy", 32'(bus.rx_busy), 32'd0);
        check_output("reset_overflow", 32'(bus.overflow_err), 32'd0);
        rst = 1'b0;
        wait_clk(4);
        check_output("reset_state", 32'(dut.state), 32'(RX_IDLE));

        $display("[TB] full frame 0x00..0x7F");
        bus.rx_enable = 1'b1;
        bus.spi_cs_n  = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 128; i++) apply_stimulus(8'(i), 1'b1, i);
        wait_clk(12);
        bus.spi_cs_n = 1'b1;
        wait_clk(8);
        check_output("t1_pending", 32'(exp_q.size()), 32'd0);
        check_output("t1_done_count", 32'(done_count), 32'd1);
        check_output("t1_state", 32'(dut.state), 32'(RX_DONE));
        check_output("t1_rx_busy", 32'(bus.rx_busy), 32'd0);

        $display("[TB] extra bytes while done");
        bus.spi_cs_n = 1'b0;
        wait_clk(6);
        apply_stimulus(8'hC3, 1'b0, 0);
        apply_stimulus(8'h3C, 1'b0, 0);
        wait_clk(12);
        bus.spi_cs_n = 1'b1;
        wait_clk(8);
        check_output("t3_overflow", 32'(bus.overflow_err), 32'd1);
        check_output("t3_state", 32'(dut.state), 32'(RX_DONE));
        pulse_clear();
        check_output("t3_overflow_cleared", 32'(bus.overflow_err), 32'd0);
        check_output("t3_state_cleared", 32'(dut.state), 32'(RX_IDLE));

        $display("[TB] partial byte then new burst");
        bus.spi_cs_n = 1'b0;
        wait_clk(6);
        send_bits(8'hA0, 3);
        bus.spi_cs_n = 1'b1;
        wait_clk(10);
        bus.spi_cs_n = 1'b0;
        wait_clk(6);
        apply_stimulus(8'hA5, 1'b1, 0);
        wait_clk(12);
        bus.spi_cs_n = 1'b1;
        wait_clk(8);
        check_output("t2_pending", 32'(exp_q.size()), 32'd0);
        check_output("t2_rx_busy", 32'(bus.rx_busy), 32'd1);
        pulse_clear();

        $display("[TB] frame split by rx_enable drop");
        bus.spi_cs_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 50; i++) apply_stimulus(8'(i) ^ 8'h5A, 1'b1, i);
        wait_clk(12);
        check_output("t4_busy_mid", 32'(bus.rx_busy), 32'd1);
        bus.spi_cs_n  = 1'b1;
        bus.rx_enable = 1'b0;
        wait_clk(8);
        check_output("t4_busy_paused", 32'(bus.rx_busy), 32'd0);
        check_output("t4_state_paused", 32'(dut.state), 32'(RX_IDLE));
        bus.rx_enable = 1'b1;
        bus.spi_cs_n  = 1'b0;
        wait_clk(6);
        for (int i = 50; i < 128; i++) apply_stimulus(8'(i) ^ 8'h5A, 1'b1, i);
        wait_clk(12);
        bus.spi_cs_n = 1'b1;
        wait_clk(8);
        check_output("t4_pending", 32'(exp_q.size()), 32'd0);
        check_output("t4_done_count", 32'(done_count), 32'd2);
        check_output("t4_state", 32'(dut.state), 32'(RX_DONE));

        $display("[TB] reset mid-frame");
        bus.rx_enable = 1'b0;
        wait_clk(6);
        pulse_clear();
        bus.rx_enable = 1'b1;
        bus.spi_cs_n  = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 10; i++) apply_stimulus(8'h30 + 8'(i), 1'b1, i);
        send_bits(8'hF0, 4);
        wait_clk(2);
        check_output("t5_busy_before", 32'(bus.rx_busy), 32'd1);
        rst = 1'b1;
        #1;
        check_output("t5_buf_we", 32'(bus.buf_we), 32'd0);
        check_output("t5_buf_addr", 32'(bus.buf_addr), 32'd0);
        check_output("t5_buf_wdata", 32'(bus.buf_wdata), 32'd0);
        check_output("t5_rx_busy", 32'(bus.rx_busy), 32'd0);
        check_output("t5_image_done", 32'(bus.image_done), 32'd0);
        check_output("t5_pending", 32'(exp_q.size()), 32'd0);
        wait_clk(3);
        rst          = 1'b0;
        bus.spi_cs_n = 1'b1;
        wait_clk(8);
        bus.spi_cs_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 128; i++) apply_stimulus(8'(255 - i), 1'b1, i);
        wait_clk(12);
        bus.spi_cs_n = 1'b1;
        wait_clk(8);
        check_output("t5_frame_pending", 32'(exp_q.size()), 32'd0);
        check_output("t5_done_count", 32'(done_count), 32'd3);
        check_output("t5_state", 32'(dut.state), 32'(RX_DONE));

        $display("[TB] burst with rx_enable low");
        bus.rx_enable = 1'b0;
        wait_clk(6);
        bus.spi_cs_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 16; i++) apply_stimulus(8'(i * 17), 1'b0, 0);
        wait_clk(12);
        bus.spi_cs_n = 1'b1;
        wait_clk(8);
        check_output("t6_state", 32'(dut.state), 32'(RX_IDLE));
        check_output("t6_rx_busy", 32'(bus.rx_busy), 32'd0);
        check_output("t6_overflow", 32'(bus.overflow_err), 32'd0);
        check_output("t6_done_count", 32'(done_count), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
